// File: rtl/conv_pass_sched.sv
// conv_pass_sched
//
// Sequencer for the streaming 3x3 convolution engines. It replays a stored
// IMG_W x IMG_H frame from the frame buffer in raster order once per kernel,
// clears the engine before each pass and steps the kernel select. It also
// tags every read so that, ENG_LAT cycles later, the engine output is
// flagged only for the (IMG_W-K+1) x (IMG_H-K+1) fully populated windows.
//
// Optional feature macro: CONV_PASS_SCHED_COORD_EN
//   defined   : out_row/out_col carry the window coordinates through the
//               tag pipeline.
//   undefined : out_row/out_col are tied to 0 and the coordinate fields are
//               left out of the tag pipeline. out_valid, out_last and all
//               timing are unchanged.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         synchronous active-high reset, highest priority
//   start       begin a frame run (sampled only in IDLE)
//   abort       cancel a run in progress (ignored in IDLE)
//   rd_en       frame-buffer read strobe
//   rd_addr     raster pixel address row*IMG_W+col
//   eng_clr     engine line-buffer/accumulator clear
//   kernel_sel  coefficient bank for the current pass
//   out_valid   engine output this cycle is a valid window
//   out_row     window row coordinate (0 when coordinates are disabled)
//   out_col     window column coordinate (0 when coordinates are disabled)
//   out_last    final valid window of the current pass
//   busy        high from CLEAR through DONE
//   done        one-cycle pulse after the last pass
module conv_pass_sched #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int K           = 3,
  parameter int NUM_KERNELS = 3,
  parameter int ENG_LAT     = 3,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              eng_clr,
  output logic [1:0]        kernel_sel,
  output logic              out_valid,
  output logic [4:0]        out_row,
  output logic [4:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int DW = $clog2(ENG_LAT) + 1;
  localparam logic [4:0]        COL_MAX    = 5'(IMG_W - 1);
  localparam logic [4:0]        ROW_MAX    = 5'(IMG_H - 1);
  localparam logic [4:0]        WIN_MIN    = 5'(K - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(ENG_LAT - 1);
  localparam logic [1:0]        PASS_LAST  = 2'(NUM_KERNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        row_q, row_d;
  logic [4:0]        col_q, col_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [1:0]        pass_q, pass_d;
  logic [ENG_LAT-1:0] win_q, win_d;
  logic [ENG_LAT-1:0] last_q, last_d;
`ifdef CONV_PASS_SCHED_COORD_EN
  logic [4:0] trow_q [ENG_LAT];
  logic [4:0] trow_d [ENG_LAT];
  logic [4:0] tcol_q [ENG_LAT];
  logic [4:0] tcol_d [ENG_LAT];
`endif

  logic streaming;
  logic flush;
  logic tag_win;
  logic tag_last;

  assign streaming = (state_q == S_STREAM);
  // abort only matters once a run is in progress
  assign flush     = abort && (state_q != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_STREAM;
      S_STREAM: if (addr_q == ADDR_LAST) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DRAIN_LAST)
                  state_d = (pass_q == PASS_LAST) ? S_DONE : S_CLEAR;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Counters: raster address/row/col restart in every CLEAR, the pass
  // counter advances at the end of each DRAIN except the last one.
  always_comb begin
    addr_d  = addr_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    pass_d  = pass_q;
    case (state_q)
      S_CLEAR: begin
        addr_d  = '0;
        row_d   = '0;
        col_d   = '0;
        drain_d = '0;
      end
      S_STREAM: begin
        addr_d = addr_q + 1'b1;
        if (col_q == COL_MAX) begin
          col_d = '0;
          row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST && pass_q != PASS_LAST)
          pass_d = pass_q + 1'b1;
      end
      S_DONE:  pass_d = '0;
      default: ;
    endcase
    if (flush) begin
      addr_d  = '0;
      row_d   = '0;
      col_d   = '0;
      drain_d = '0;
      pass_d  = '0;
    end
  end

  // Tag pipeline: each read pushes a tag that lines up with the engine
  // output ENG_LAT cycles later. Non-read cycles push an empty tag.
  always_comb begin
    tag_win  = streaming && (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
    tag_last = streaming && (row_q == ROW_MAX) && (col_q == COL_MAX);
    win_d    = {win_q[ENG_LAT-2:0], tag_win};
    last_d   = {last_q[ENG_LAT-2:0], tag_last};
    if (flush) begin
      win_d  = '0;
      last_d = '0;
    end
  end

`ifdef CONV_PASS_SCHED_COORD_EN
  // Coordinates are zeroed for non-window tags so idle outputs stay 0.
  always_comb begin
    trow_d[0] = tag_win ? row_q - WIN_MIN : '0;
    tcol_d[0] = tag_win ? col_q - WIN_MIN : '0;
    for (int i = 1; i < ENG_LAT; i++) begin
      trow_d[i] = trow_q[i-1];
      tcol_d[i] = tcol_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < ENG_LAT; i++) begin
        trow_d[i] = '0;
        tcol_d[i] = '0;
      end
    end
  end
`endif

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      pass_q  <= '0;
      win_q   <= '0;
      last_q  <= '0;
`ifdef CONV_PASS_SCHED_COORD_EN
      for (int i = 0; i < ENG_LAT; i++) begin
        trow_q[i] <= '0;
        tcol_q[i] <= '0;
      end
`endif
    end else begin
      addr_q  <= addr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
      win_q   <= win_d;
      last_q  <= last_d;
`ifdef CONV_PASS_SCHED_COORD_EN
      for (int i = 0; i < ENG_LAT; i++) begin
        trow_q[i] <= trow_d[i];
        tcol_q[i] <= tcol_d[i];
      end
`endif
    end
  end

  // Output logic
  always_comb begin
    rd_en      = streaming;
    rd_addr    = streaming ? addr_q : '0;
    eng_clr    = (state_q == S_CLEAR);
    kernel_sel = (state_q == S_CLEAR || state_q == S_STREAM ||
                  state_q == S_DRAIN) ? pass_q : '0;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    out_valid  = win_q[ENG_LAT-1];
    out_last   = last_q[ENG_LAT-1];
`ifdef CONV_PASS_SCHED_COORD_EN
    out_row    = trow_q[ENG_LAT-1];
    out_col    = tcol_q[ENG_LAT-1];
`else
    out_row    = '0;
    out_col    = '0;
`endif
  end

endmodule

// File: tb/tb_conv_pass_sched.sv
// tb_conv_pass_sched
//
// Directed bench for conv_pass_sched with the default 28x28 frame, 3x3
// kernel, three passes and ENG_LAT=3. Run cycle k counts from the start
// cycle T (k=1 is T+1); outputs are sampled on the falling edge and
// compared against a pixel-index model of the expected schedule.
module tb_conv_pass_sched;

  localparam int PASS_LEN  = 788;
  localparam int RUN_END   = 3 * PASS_LEN;
  localparam int DONE_K    = RUN_END + 1;

  typedef struct packed {
    logic       rd_en;
    logic [9:0] rd_addr;
    logic       eng_clr;
    logic [1:0] ksel;
    logic       ov;
    logic [4:0] orow;
    logic [4:0] ocol;
    logic       olast;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic       eng_clr;
  logic [1:0] kernel_sel;
  logic       out_valid;
  logic [4:0] out_row;
  logic [4:0] out_col;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  conv_pass_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .eng_clr    (eng_clr),
    .kernel_sel (kernel_sel),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return {rd_en, rd_addr, eng_clr, kernel_sel, out_valid,
            out_row, out_col, out_last, busy, done};
  endfunction

  // Expected outputs for run cycle k, worked out from the pixel index.
  function automatic obs_t model(input int k);
    obs_t e;
    int p, o, n, r, c;
    e = '0;
    if (k >= 1 && k <= RUN_END) begin
      p = (k - 1) / PASS_LEN;
      o = (k - 1) % PASS_LEN;
      e.busy = 1'b1;
      e.ksel = 2'(p);
      if (o == 0) e.eng_clr = 1'b1;
      if (o >= 1 && o <= 784) begin
        e.rd_en   = 1'b1;
        e.rd_addr = 10'(o - 1);
      end
      if (o >= 4 && o <= 787) begin
        n = o - 4;
        r = n / 28;
        c = n % 28;
        if (r >= 2 && c >= 2) begin
          e.ov = 1'b1;
`ifdef CONV_PASS_SCHED_COORD_EN
          e.orow = 5'(r - 2);
          e.ocol = 5'(c - 2);
`endif
          e.olast = (n == 783);
        end
      end
    end else if (k == DONE_K) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t obs;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    obs = sample();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs got=%h exp=%h", obs, obs_t'('0));
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    obs = sample();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_release got=%h exp=%h", obs, obs_t'('0));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    obs = sample();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL abort_in_idle got=%h exp=%h", obs, obs_t'('0));
    end
  endtask

  task automatic test_full_run();
    obs_t obs, exp;
    int valid_cnt = 0;
    int first_k = -1;
    int last_k = -1;
    logic [9:0] first_rc = '0;
    logic [9:0] last_rc = '0;
    logic [9:0] last_rc_exp;
`ifdef CONV_PASS_SCHED_COORD_EN
    last_rc_exp = {5'd25, 5'd25};
`else
    last_rc_exp = '0;
`endif
    launch();
    for (int k = 1; k <= DONE_K + 1; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL full_run k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (obs.ov === 1'b1) begin
        valid_cnt++;
        if (first_k < 0) begin
          first_k  = k;
          first_rc = {obs.orow, obs.ocol};
        end
      end
      if (obs.olast === 1'b1 && last_k < 0) begin
        last_k  = k;
        last_rc = {obs.orow, obs.ocol};
      end
      @(negedge clk);
    end
    n_checks++;
    if (valid_cnt != 2028) begin
      n_fail++;
      $display("[TB] FAIL valid_count got=%0d exp=2028", valid_cnt);
    end
    n_checks++;
    if (first_k != 63 || first_rc !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL first_valid got k=%0d rc=%h exp k=63 rc=000", first_k, first_rc);
    end
    n_checks++;
    if (last_k != 788 || last_rc !== last_rc_exp) begin
      n_fail++;
      $display("[TB] FAIL first_last got k=%0d rc=%h exp k=788 rc=%h", last_k, last_rc, last_rc_exp);
    end
  endtask

  task automatic test_abort();
    obs_t obs, exp;
    launch();
    for (int k = 1; k <= 400; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL abort_prefix k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 400) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    for (int i = 0; i < 12; i++) begin
      obs = sample();
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("[TB] FAIL abort_idle i=%0d got=%h exp=%h", i, obs, obs_t'('0));
      end
      @(negedge clk);
    end
    launch();
    for (int k = 1; k <= 100; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL abort_rerun k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 100) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t obs, exp;
    launch();
    for (int k = 1; k <= DONE_K + 1; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL busy_start k=%0d got=%h exp=%h", k, obs, exp);
      end
      start = (k == 10 || k == DONE_K || k == DONE_K + 1);
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL restart k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 2) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    obs = sample();
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("[TB] FAIL restart_abort got=%h exp=%h", obs, obs_t'('0));
    end
  endtask

  task automatic test_reset_mid();
    obs_t obs, exp;
    launch();
    for (int k = 1; k <= 1000; k++) begin
      obs = sample();
      exp = model(k);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_prefix k=%0d got=%h exp=%h", k, obs, exp);
      end
      if (k == 1000) rst = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < 14; i++) begin
      obs = sample();
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_flush i=%0d got=%h exp=%h", i, obs, obs_t'('0));
      end
      if (i == 1) rst = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] conv_pass_sched bench starting");
    test_reset();
    test_full_run();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
